booth_mult_seq_arb: RTL
=======================

// Module: booth_mult_seq_arb
// PURPOSE
//  Iterative radix-2 Booth multiplier engine shared between two requesters.
//  Performs one Booth add/sub + arithmetic-shift step per clock, over WIDTH clocks.
//  Uses the same A/Q/Q-1 recurrence as the unrolled combinational multiplier.
//  Gives an area-cheap signed multiply for control paths that do not need
//  single-cycle results. Includes round-robin arbitration and valid/ready handshakes.
// PARAMETERS
//  WIDTH  25  operand width (signed two's complement); product is 2*WIDTH bits
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         synchronous reset, active low
//  req0_valid   in   1         requester 0 has operands
//  req0_ready   out  1         requester 0 operands accepted this cycle
//  req0_m       in   WIDTH     requester 0 multiplicand M (signed)
//  req0_q       in   WIDTH     requester 0 multiplier Q (signed)
//  req1_valid   in   1         requester 1 has operands
//  req1_ready   out  1         requester 1 operands accepted this cycle
//  req1_m       in   WIDTH     requester 1 multiplicand M
//  req1_q       in   WIDTH     requester 1 multiplier Q
//  res_valid    out  1         product valid
//  res_ready    in   1         consumer accepts product
//  res_z        out  2*WIDTH   signed product M*Q
//  res_id       out  1         requester that owns res_z
//  busy         out  1         high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; res_valid=0; res_z=0; res_id=0.
//   Also busy=0, rr_ptr=0 (req0 preferred), internal A/Q/count cleared.
//  Reset has priority over all other events. An in-flight operation is discarded
//   with no result. Both readies stay 0 while rst_n=0.
//  State IDLE:
//   - reqX_ready is combinational: state==IDLE && grant==X.
//   - At most one ready is high per cycle.
//   - Grant rule: if only one valid, grant it. If both valid, grant rr_ptr and
//     set rr_ptr to the other requester.
//   - On the accept edge: latch M and Q; set A={WIDTH+1{0}}, Qx={Q,1'b0}, cnt=0;
//     set res_id=grant; go to RUN.
//  State RUN, one step per edge:
//   - Add/sub on Qx[1:0]: 01 -> A=A+sxt(M); 10 -> A=A-sxt(M); 00/11 -> no change.
//   - Then arithmetic-shift {A,Qx} right by 1; A MSB is replicated.
//   - A is WIDTH+1 bits, so M=-2^(WIDTH-1) is exact.
//   - cnt increments each step; after step WIDTH (cnt==WIDTH-1 at edge) go to DONE.
//   - The step edge that enters DONE also loads res_z = {A[WIDTH-1:0], Qx[WIDTH:1]}.
//  State DONE:
//   - res_valid=1. res_z and res_id are held stable until res_valid && res_ready.
//   - On that handshake edge: res_valid=0, go to IDLE.
//   - res_z keeps its last value after the handshake.
//  Timing:
//   - Latency: accept edge T0, steps at T1..T(WIDTH); res_valid high from T(WIDTH).
//   - Minimum initiation interval is WIDTH+2 cycles, because IDLE lasts at least one cycle.
//  Input sampling:
//   - Operand or valid changes during RUN/DONE are ignored.
//   - Requesters must hold valid until ready; a dropped valid is not remembered.
//   - res_ready while res_valid=0 has no effect.
//  Product range: every WIDTH x WIDTH signed product, incl. (-2^(W-1))^2, is exact in 2*WIDTH bits.
// TESTING
//  1 reset: rst_n=0 then 1 -> res_valid=0, readies low until valid, busy=0.
//  2 single: req0 M=3, Q=-5 -> req0_ready 1 cycle; res_valid at T25; res_z=-15 (50'h3FFFFFFFFFFF1), res_id=0.
//  3 corner: M=Q=-2^24 -> res_z=2^48. M=-2^24, Q=2^24-1 -> res_z=-2^48+2^24.
//  4 RR: both valid continuously -> grants alternate 0,1,0,1; each res_id matches.
//     Products are correct (random 1000 pairs vs $signed ref).
//  5 backpressure: res_ready=0 for 10 cycles in DONE -> res_z/res_id stable, no new grant.
//     Release -> IDLE, next grant.
//  6 mid-op reset: rst_n=0 at step 12 -> no res_valid. The next request completes
//     correctly with rr_ptr=0.

Source files
------------

// File: rtl/booth_mult_seq_arb.sv
// Iterative radix-2 Booth multiplier shared between two requesters.
// A round-robin arbiter picks one requester while the engine is idle. The
// engine then runs one add/sub plus arithmetic-shift step per clock for WIDTH
// clocks and holds the signed product until the consumer takes it.
module booth_mult_seq_arb #(
    parameter int WIDTH = 25
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [WIDTH-1:0]     req0_m_i,
    input  logic [WIDTH-1:0]     req0_q_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [WIDTH-1:0]     req1_m_i,
    input  logic [WIDTH-1:0]     req1_q_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [2*WIDTH-1:0]   res_z_o,
    output logic                 res_id_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rrPtr_q, rrPtr_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH:0]       qx_q, qx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   resZ_q, resZ_d;
    logic                 resId_q, resId_d;

    logic                 bothValid;
    logic                 grantId;
    logic                 accept;
    logic [WIDTH:0]       multExt;
    logic [WIDTH:0]       addSub;
    logic [WIDTH:0]       accShift;
    logic [WIDTH:0]       qxShift;

    // Arbitration: a lone valid wins; on contention the round-robin pointer decides.
    always_comb begin
        bothValid = req0_valid_i & req1_valid_i;
        grantId   = bothValid ? rrPtr_q : req1_valid_i;
        accept    = rst_n_i && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    end

    assign req0_ready_o = accept && !grantId;
    assign req1_ready_o = accept && grantId;

    // One Booth step: add/sub the sign-extended multiplicand, then shift {A,Qx} right arithmetically.
    always_comb begin
        multExt = {mult_q[WIDTH-1], mult_q};
        unique case (qx_q[1:0])
            2'b01:   addSub = acc_q + multExt;
            2'b10:   addSub = acc_q - multExt;
            default: addSub = acc_q;
        endcase
        accShift = {addSub[WIDTH], addSub[WIDTH:1]};
        qxShift  = {addSub[0], qx_q[WIDTH:1]};
    end

    // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        qx_d    = qx_q;
        cnt_d   = cnt_q;
        resZ_d  = resZ_q;
        resId_d = resId_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mult_d  = grantId ? req1_m_i : req0_m_i;
                    qx_d    = {(grantId ? req1_q_i : req0_q_i), 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    resId_d = grantId;
                    if (bothValid) begin
                        rrPtr_d = ~grantId;
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = accShift;
                qx_d  = qxShift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    resZ_d  = {accShift[WIDTH-1:0], qxShift[WIDTH:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rrPtr_q <= 1'b0;
            mult_q  <= '0;
            acc_q   <= '0;
            qx_q    <= '0;
            cnt_q   <= '0;
            resZ_q  <= '0;
            resId_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            qx_q    <= qx_d;
            cnt_q   <= cnt_d;
            resZ_q  <= resZ_d;
            resId_q <= resId_d;
        end
    end

    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign res_z_o     = resZ_q;
    assign res_id_o    = resId_q;

endmodule
